// File: rtl/eth_pkt_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkt_pkg: packet-type codes shared with eth_send, scheduler state enum.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package eth_pkt_pkg;

  localparam logic [3:0] PKT_NONE = 4'd0;
  localparam logic [3:0] ARP_REQ  = 4'd1;
  localparam logic [3:0] ARP_RESP = 4'd2;
  localparam logic [3:0] UDP      = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARP_RESP = 3'd1,
    S_ARP_REQ  = 3'd2,
    S_UDP_ARM  = 3'd3,
    S_UDP_RUN  = 3'd4,
    S_GAP      = 3'd5
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fall_det.sv
// ----------------------------------------------------------------------------
// sync_fall_det: 2-flop synchronizer with a registered one-cycle falling-edge pulse.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fall_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  // Idle level of an active-low strobe is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
      fall   <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
      fall   <= sync_d & ~sync;
    end
  end

endmodule

`default_nettype wire

// File: rtl/eth_tx_sched.sv
// ----------------------------------------------------------------------------
// eth_tx_sched: arbitrates ARP response / ARP request / UDP burst jobs for eth_send.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module eth_tx_sched
  import eth_pkt_pkg::*;
#(
  parameter int unsigned UDP_FRAGS        = 4,
  parameter logic [23:0] ARP_RETRY_CYCLES = 24'd10_000_000,
  parameter logic [7:0]  IFG_CYCLES       = 8'd16,
  parameter logic [19:0] TX_TIMEOUT       = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_msync_n,
  input  logic        i_arp_resp_req,
  input  logic        i_target_mac_vld,
  input  logic        i_tx_vld,
  input  logic        i_tx_eop,
  input  logic        i_tx_rdy,
  output logic [3:0]  o_pkt_type,
  output logic        o_msync_n,
  output logic        o_busy,
  output logic [15:0] o_udp_drop_cnt,
  output logic        o_err
);

  localparam logic [7:0] FRAG_LAST = 8'(UDP_FRAGS - 1);

  sched_state_e state, state_nxt;
  logic [3:0]   pkt_type, pkt_type_nxt;
  logic         msync_q, msync_nxt;
  logic         err_q, err_nxt;
  logic         resp_pend, resp_pend_nxt;
  logic         udp_pend, udp_pend_nxt;
  logic         req_pend, req_pend_nxt;
  logic [15:0]  drop_cnt, drop_cnt_nxt;
  logic [23:0]  retry_cnt, retry_cnt_nxt;
  logic [7:0]   frag_cnt, frag_cnt_nxt;
  logic [19:0]  to_cnt, to_cnt_nxt;
  logic [7:0]   gap_cnt, gap_cnt_nxt;
  logic         sync_fall;
  logic         done;
  logic         retry_wrap;
  logic         set_udp;
  logic         clr_resp, clr_udp, clr_req;

  sync_fall_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (i_msync_n),
    .fall  (sync_fall)
  );

  assign done = i_tx_vld & i_tx_eop & i_tx_rdy;

  always_comb begin
    state_nxt     = state;
    pkt_type_nxt  = pkt_type;
    msync_nxt     = 1'b1;
    err_nxt       = 1'b0;
    frag_cnt_nxt  = frag_cnt;
    to_cnt_nxt    = to_cnt;
    gap_cnt_nxt   = gap_cnt;
    drop_cnt_nxt  = drop_cnt;
    retry_cnt_nxt = retry_cnt;
    retry_wrap    = 1'b0;
    set_udp       = 1'b0;
    clr_resp      = 1'b0;
    clr_udp       = 1'b0;
    clr_req       = 1'b0;

    if (i_target_mac_vld) begin
      retry_cnt_nxt = '0;
    end else if (retry_cnt == ARP_RETRY_CYCLES - 24'd1) begin
      retry_cnt_nxt = '0;
      retry_wrap    = 1'b1;
    end else begin
      retry_cnt_nxt = retry_cnt + 24'd1;
    end

    // A sync while a burst is queued or in flight cannot be honoured: count it.
    if (sync_fall) begin
      if (udp_pend || state == S_UDP_ARM || state == S_UDP_RUN) begin
        if (drop_cnt != 16'hFFFF) drop_cnt_nxt = drop_cnt + 16'd1;
      end else begin
        set_udp = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        frag_cnt_nxt = '0;
        to_cnt_nxt   = '0;
        gap_cnt_nxt  = '0;
        if (resp_pend) begin
          state_nxt    = S_ARP_RESP;
          pkt_type_nxt = ARP_RESP;
          clr_resp     = 1'b1;
        end else if (udp_pend && i_target_mac_vld) begin
          state_nxt    = S_UDP_ARM;
          pkt_type_nxt = UDP;
          clr_udp      = 1'b1;
        end else if (req_pend) begin
          state_nxt    = S_ARP_REQ;
          pkt_type_nxt = ARP_REQ;
          clr_req      = 1'b1;
        end
      end
      S_UDP_ARM: begin
        // Type is already UDP; the regenerated sync edge follows one cycle later.
        state_nxt = S_UDP_RUN;
        msync_nxt = 1'b0;
      end
      S_ARP_RESP, S_ARP_REQ, S_UDP_RUN: begin
        if (done) begin
          to_cnt_nxt = '0;
          if (state != S_UDP_RUN || frag_cnt == FRAG_LAST) begin
            state_nxt    = S_GAP;
            pkt_type_nxt = PKT_NONE;
            frag_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
          end else begin
            frag_cnt_nxt = frag_cnt + 8'd1;
          end
        end else if (to_cnt == TX_TIMEOUT - 20'd1) begin
          err_nxt      = 1'b1;
          state_nxt    = S_GAP;
          pkt_type_nxt = PKT_NONE;
          to_cnt_nxt   = '0;
          frag_cnt_nxt = '0;
          gap_cnt_nxt  = '0;
        end else begin
          to_cnt_nxt = to_cnt + 20'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt == IFG_CYCLES - 8'd1) state_nxt = S_IDLE;
        else                              gap_cnt_nxt = gap_cnt + 8'd1;
      end
      default: begin
        state_nxt    = S_IDLE;
        pkt_type_nxt = PKT_NONE;
      end
    endcase

    resp_pend_nxt = (resp_pend & ~clr_resp) | i_arp_resp_req;
    udp_pend_nxt  = (udp_pend & ~clr_udp) | set_udp;
    req_pend_nxt  = i_target_mac_vld ? 1'b0 : ((req_pend & ~clr_req) | retry_wrap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pkt_type  <= PKT_NONE;
      msync_q   <= 1'b1;
      err_q     <= 1'b0;
      resp_pend <= 1'b0;
      udp_pend  <= 1'b0;
      req_pend  <= 1'b0;
      drop_cnt  <= '0;
      retry_cnt <= '0;
      frag_cnt  <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      pkt_type  <= pkt_type_nxt;
      msync_q   <= msync_nxt;
      err_q     <= err_nxt;
      resp_pend <= resp_pend_nxt;
      udp_pend  <= udp_pend_nxt;
      req_pend  <= req_pend_nxt;
      drop_cnt  <= drop_cnt_nxt;
      retry_cnt <= retry_cnt_nxt;
      frag_cnt  <= frag_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
    end
  end

  assign o_pkt_type     = pkt_type;
  assign o_msync_n      = msync_q;
  assign o_busy         = (state != S_IDLE);
  assign o_udp_drop_cnt = drop_cnt;
  assign o_err          = err_q;

endmodule

`default_nettype wire

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
Transmit scheduler in front of eth_send. It arbitrates three frame sources and drives the packet-type select of the shared Ethernet transmitter: ARP responses requested by the receive path, periodic ARP requests until the target MAC is resolved, and UDP bursts triggered by main sync. It also regenerates the main-sync strobe so that the transmitter only sees a sync edge once the UDP type is already selected. It counts frame completions on the Avalon-ST style output handshake and inserts an inter-burst gap.

Parameters:
UDP_FRAGS, 4, number of UDP frames per sync burst (4800 data bytes at 1400 bytes per fragment gives 1400/1400/1400/600).
ARP_RETRY_CYCLES, 24'd10_000_000, spacing of ARP requests while the target MAC is unresolved.
IFG_CYCLES, 8'd16, idle cycles with type 0 after every completed job.
TX_TIMEOUT, 20'd1_000_000, maximum cycles in a send state without a completing EOP.

Ports:
clk  in  1  transmitter clock; all logic is on this clock.
rst_n  in  1  asynchronous active-low reset.
i_msync_n  in  1  main sync, active-low, asynchronous to clk.
i_arp_resp_req  in  1  one-cycle pulse: an ARP request addressed to us was received.
i_target_mac_vld  in  1  high when the target MAC is resolved (level).
i_tx_vld  in  1  eth_send o_vld.
i_tx_eop  in  1  eth_send o_eop.
i_tx_rdy  in  1  MAC sink ready; the same signal that feeds eth_send i_rdy.
o_pkt_type  out  4  to eth_send i_pkt_type: 0 idle, 1 ARP_REQ, 2 ARP_RESP, 3 UDP.
o_msync_n  out  1  to eth_send i_msync_n; regenerated sync.
o_busy  out  1  high in any state other than IDLE.
o_udp_drop_cnt  out  16  syncs lost because a UDP burst was already pending or active; saturating.
o_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values: o_pkt_type=0, o_msync_n=1, o_busy=0, o_udp_drop_cnt=0, o_err=0. Reset also clears all pending flags, the retry timer and the frame counter. Reset asserted mid-frame aborts immediately.
- Sync input:
  - i_msync_n passes through a 2-flop synchronizer.
  - A falling edge on the synchronized signal sets udp_pend.
  - If udp_pend is already set, or the state is UDP_ARM or UDP_RUN, the edge instead increments o_udp_drop_cnt, saturating at 16'hFFFF.
- ARP response request: i_arp_resp_req sets resp_pend. Repeated pulses merge into the one pending flag.
- ARP retry timer:
  - Counts only while ~i_target_mac_vld.
  - At ARP_RETRY_CYCLES-1 it wraps and sets req_pend.
  - It is held at 0 while the MAC is valid, and req_pend is cleared whenever i_target_mac_vld=1.
- Completion event: done = i_tx_vld & i_tx_eop & i_tx_rdy. done is evaluated only in the send states.
- States: IDLE, ARP_RESP, ARP_REQ, UDP_ARM, UDP_RUN, GAP.
- IDLE: selects one job per cycle, priority resp_pend > udp_pend (only if i_target_mac_vld) > req_pend.
  - The chosen pending flag clears on entry to the job's state.
  - o_pkt_type is registered and takes the new value in the same cycle as the state.
  - udp_pend with MAC unresolved stays pending; it is not dropped.
- ARP_RESP / ARP_REQ: o_pkt_type=2 or 1. On done, go to GAP; o_pkt_type is 0 from the next cycle. eth_send sees step 0 together with type 0, so no second frame starts.
- UDP_ARM: o_pkt_type=3 and o_msync_n=1 for exactly 1 cycle, then go to UDP_RUN.
- UDP_RUN:
  - o_msync_n=0 in the first cycle only, then 1. This gives eth_send exactly one falling edge with type already 3.
  - frag_cnt starts at 0 and increments on each done.
  - On done with frag_cnt==UDP_FRAGS-1, go to GAP with o_pkt_type=0 next cycle.
- GAP: o_pkt_type=0 for IFG_CYCLES cycles, then IDLE. Pending events arriving during GAP are latched and served afterwards.
- Timeout:
  - A cycle counter runs in ARP_RESP, ARP_REQ and UDP_RUN and resets on every done.
  - When it reaches TX_TIMEOUT, pulse o_err for 1 cycle and go to GAP with type 0.
  - The aborted job is not retried.
- Simultaneous events: a sync edge and i_arp_resp_req in the same cycle set both flags, and ARP_RESP is served first.
- i_tx_rdy low stalls the transmitter; done is simply not seen, so the scheduler holds its state.

Decomposition:
- Shared package eth_pkt_pkg: the packet-type constants (PKT_NONE=0, ARP_REQ=1, ARP_RESP=2, UDP=3), shared with eth_send, and the state enum.
- One sub-module: sync_fall_det (2-flop synchronizer plus registered falling-edge pulse), reusable wherever main sync crosses into clk.

Test Plan:
- MAC valid, i_tx_rdy=1, one sync falling edge -> type 3 one cycle before o_msync_n low for exactly 1 cycle; 4 done events; type=0 one cycle after the 4th EOP; o_busy low after 16 gap cycles.
- i_target_mac_vld=0, ARP_RETRY_CYCLES=100 -> type 1 issued at cycle 100, 200, ...; each held until its EOP. Raise MAC valid -> no further requests.
- i_arp_resp_req pulse in the same cycle as a sync edge -> ARP_RESP frame first, 16-cycle gap, then the UDP burst of 4 frames; o_udp_drop_cnt stays 0.
- Second sync edge during UDP_RUN and a third during GAP -> o_udp_drop_cnt=1; the GAP-time edge is latched and a new burst starts after the gap.
- i_tx_rdy held low with TX_TIMEOUT=50 during ARP_REQ -> o_err pulses once at cycle 50; type 0 next cycle; GAP then IDLE.
- rst_n asserted in the middle of UDP frame 2 -> all outputs at reset values asynchronously; after release, no job starts without a new event.
